// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: Moore FSM with registered control outputs and a retire counter.
// Optional jump support is enabled by defining MC_JUMP_EN.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       func,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    START  = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9
`ifdef MC_JUMP_EN
    , JUMP = 4'd10
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  state_t state, nxt;
  logic   goIllegal, retire, pcWriteQ, fetchDone;

  logic   dPCWrite, dPCWriteCond, dIorD, dMemRead, dMemWrite;
  logic   dMemtoReg, dRegDst, dRegWrite, dALUSrcA;
  logic [1:0] dALUSrcB, dPCSource;
  logic [2:0] dALUop;

  // Zero only gates PCWriteCond inside the datapath; the sequencer never branches on it.
  logic unused_zero;
  assign unused_zero = Zero;

  function automatic logic rtypeOk(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR);
  endfunction

  function automatic logic [2:0] aluForFunc(input logic [5:0] f);
    logic [2:0] op;
    case (f)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // IR and PC load the instant the fetch read completes, so these follow mem_ready directly.
  assign fetchDone = (state == FETCH) && mem_ready;
  assign IRWrite   = fetchDone;
  assign PCWrite   = pcWriteQ | fetchDone;
  assign state_o   = state;

  // Next-state, illegal-decode and retire decisions.
  always_comb begin
    nxt       = state;
    goIllegal = 1'b0;
    retire    = 1'b0;
    case (state)
      START:  nxt = FETCH;
      FETCH:  if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (OpCode)
          OP_RTYPE: begin
            if (rtypeOk(func)) begin
              nxt = EXEC;
            end else begin
              nxt       = FETCH;
              goIllegal = 1'b1;
            end
          end
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BRANCH;
`ifdef MC_JUMP_EN
          OP_J:         nxt = JUMP;
`endif
          default: begin
            nxt       = FETCH;
            goIllegal = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (OpCode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) nxt = MEMWB;
      MEMWB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      MEMWR: begin
        if (mem_ready) begin
          nxt    = FETCH;
          retire = 1'b1;
        end
      end
      EXEC:   nxt = RWB;
      RWB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      BRANCH: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
`ifdef MC_JUMP_EN
      JUMP: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
`endif
      default: nxt = START;
    endcase
  end

  // Moore control word for the state being entered; registered below so outputs are glitch-free.
  // START drives an all-zero word, matching the reset value.
  always_comb begin
    dPCWrite     = 1'b0;
    dPCWriteCond = 1'b0;
    dIorD        = 1'b0;
    dMemRead     = 1'b0;
    dMemWrite    = 1'b0;
    dMemtoReg    = 1'b0;
    dRegDst      = 1'b0;
    dRegWrite    = 1'b0;
    dALUSrcA     = 1'b0;
    dALUSrcB     = 2'b00;
    dALUop       = ALU_ADD;
    dPCSource    = 2'b00;
    case (nxt)
      START:  dALUop = 3'b000;
      FETCH: begin
        dMemRead = 1'b1;
        dALUSrcB = 2'b01;
      end
      DECODE: dALUSrcB = 2'b11;
      MEMADR: begin
        dALUSrcA = 1'b1;
        dALUSrcB = 2'b10;
      end
      MEMRD: begin
        dMemRead = 1'b1;
        dIorD    = 1'b1;
      end
      MEMWB: begin
        dRegWrite = 1'b1;
        dMemtoReg = 1'b1;
      end
      MEMWR: begin
        dMemWrite = 1'b1;
        dIorD     = 1'b1;
      end
      EXEC: begin
        dALUSrcA = 1'b1;
        dALUop   = aluForFunc(func);
      end
      RWB: begin
        dRegWrite = 1'b1;
        dRegDst   = 1'b1;
      end
      BRANCH: begin
        dALUSrcA     = 1'b1;
        dALUop       = ALU_SUB;
        dPCWriteCond = 1'b1;
        dPCSource    = 2'b01;
      end
`ifdef MC_JUMP_EN
      JUMP: begin
        dPCWrite  = 1'b1;
        dPCSource = 2'b10;
      end
`endif
      default: dALUop = 3'b000;
    endcase
  end

  // State, registered outputs, sticky illegal flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= START;
      pcWriteQ      <= 1'b0;
      PCWriteCond   <= 1'b0;
      IorD          <= 1'b0;
      MemRead       <= 1'b0;
      MemWrite      <= 1'b0;
      MemtoReg      <= 1'b0;
      RegDst        <= 1'b0;
      RegWrite      <= 1'b0;
      ALUSrcA       <= 1'b0;
      ALUSrcB       <= 2'b00;
      ALUop         <= 3'b000;
      PCSource      <= 2'b00;
      illegal       <= 1'b0;
      instr_retired <= '0;
    end else begin
      state       <= nxt;
      pcWriteQ    <= dPCWrite;
      PCWriteCond <= dPCWriteCond;
      IorD        <= dIorD;
      MemRead     <= dMemRead;
      MemWrite    <= dMemWrite;
      MemtoReg    <= dMemtoReg;
      RegDst      <= dRegDst;
      RegWrite    <= dRegWrite;
      ALUSrcA     <= dALUSrcA;
      ALUSrcB     <= dALUSrcB;
      ALUop       <= dALUop;
      PCSource    <= dPCSource;
      if (goIllegal) illegal <= 1'b1;
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: table-driven instruction vectors, a reset-mid-MEMRD sequence,
// a counter wrap run and randomized instructions checked against a per-instruction path model.
module tb_mips_multicycle_ctrl;
  localparam int CNT_W = 4;
`ifdef MC_JUMP_EN
  localparam bit JMP = 1'b1;
`else
  localparam bit JMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [5:0] OpCode, func;
  logic Zero, mem_ready;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUop;
  logic illegal;
  logic [CNT_W-1:0] instr_retired;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .func(func), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .illegal(illegal), .instr_retired(instr_retired), .state_o(state_o)
  );

  logic [16:0] dutWord;
  assign dutWord = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource};

  int nVec = 0;
  int nBad = 0;
  int modelCnt = 0;
  bit modelIllegal = 1'b0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         waitFetch;
    int         waitMem;
    logic       zero;
    bit         legal;
  } vec_t;

  vec_t tbl[$];

  // Control word the spec tables give for a state; IRWrite/PCWrite in FETCH follow mem_ready.
  function automatic logic [16:0] expWord(int st, logic [5:0] fn, logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcs;
    logic [2:0] op;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00;
    pcs  = 2'b00;
    op   = 3'b010;
    case (st)
      0: op = 3'b000;
      1: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      2: srcb = 2'b11;
      3: begin srca = 1; srcb = 2'b10; end
      4: begin mrd = 1; iord = 1; end
      5: begin rw = 1; m2r = 1; end
      6: begin mwr = 1; iord = 1; end
      7: begin
        srca = 1;
        if (fn == 6'd32) op = 3'b010;
        else if (fn == 6'd34) op = 3'b110;
        else if (fn == 6'd36) op = 3'b000;
        else op = 3'b001;
      end
      8: begin rw = 1; rdst = 1; end
      9: begin srca = 1; op = 3'b110; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
      default: op = 3'b000;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, op, pcs};
  endfunction

  // Instruction class: 0 illegal, 1 R-type, 2 lw, 3 sw, 4 beq, 5 jump.
  function automatic int iclass(logic [5:0] op, logic [5:0] fn);
    if (op == 6'd0) return (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37) ? 1 : 0;
    if (op == 6'b100011) return 2;
    if (op == 6'b101011) return 3;
    if (op == 6'b000100) return 4;
    if (op == 6'b000010 && JMP) return 5;
    return 0;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkAllZero(string name);
    checkOutput({name, "_state"}, 32'(state_o), 32'd0);
    checkOutput({name, "_ctrl"}, 32'(dutWord), 32'd0);
    checkOutput({name, "_retired"}, 32'(instr_retired), 32'd0);
    checkOutput({name, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  // Async reset asserted at a negedge, held across one rising edge, then released into START.
  task automatic doReset();
    rst = 1'b1;
    mem_ready = 1'b1;
    #1 checkAllZero("rst_async");
    @(negedge clk);
    #1 checkAllZero("rst_held");
    rst = 1'b0;
    #1 checkOutput("start_state", 32'(state_o), 32'd0);
    modelCnt = 0;
    modelIllegal = 1'b0;
  endtask

  // Runs one instruction: builds the expected state path from the instruction class and
  // wait counts, then drives/checks it cycle by cycle. cut >= 0 resets at that path index.
  task automatic applyStimulus(logic [5:0] op, logic [5:0] fn, int wf, int wm,
                               logic zero, bit randZero, bit legal, int cut);
    int path[$];
    int cls;
    logic mr;
    cls = iclass(op, fn);
    repeat (wf) path.push_back(1);
    path.push_back(1);
    path.push_back(2);
    case (cls)
      1: begin path.push_back(7); path.push_back(8); end
      2: begin path.push_back(3); repeat (wm + 1) path.push_back(4); path.push_back(5); end
      3: begin path.push_back(3); repeat (wm + 1) path.push_back(6); end
      4: path.push_back(9);
      5: path.push_back(10);
      default: ;
    endcase
    for (int i = 0; i < path.size(); i++) begin
      @(negedge clk);
      if (i == cut) begin
        doReset();
        return;
      end
      OpCode = op;
      func   = fn;
      Zero   = randZero ? 1'($urandom) : zero;
      if (path[i] == 1 || path[i] == 4 || path[i] == 6)
        mr = (i + 1 == path.size()) || (path[i + 1] != path[i]);
      else
        mr = 1'($urandom);
      mem_ready = mr;
      #1;
      checkOutput("state", 32'(state_o), 32'(path[i]));
      checkOutput("ctrl", 32'(dutWord), 32'(expWord(path[i], fn, mr)));
      if (i == 0) begin
        checkOutput("retired", 32'(instr_retired), 32'(modelCnt));
        checkOutput("illegal", 32'(illegal), 32'(modelIllegal));
      end
    end
    if (legal) modelCnt = (modelCnt + 1) % (1 << CNT_W);
    else modelIllegal = 1'b1;
  endtask

  initial begin
    logic [5:0] rop, rfn;
    OpCode = '0;
    func = '0;
    Zero = 1'b0;
    mem_ready = 1'b0;
    rst = 1'b0;

    tbl.push_back('{6'b000000, 6'b100000, 0, 0, 1'b0, 1'b1});
    tbl.push_back('{6'b000000, 6'b100010, 1, 0, 1'b0, 1'b1});
    tbl.push_back('{6'b000000, 6'b100100, 0, 0, 1'b1, 1'b1});
    tbl.push_back('{6'b000000, 6'b100101, 2, 0, 1'b0, 1'b1});
    tbl.push_back('{6'b100011, 6'b000000, 0, 3, 1'b0, 1'b1});
    tbl.push_back('{6'b101011, 6'b000000, 0, 0, 1'b0, 1'b1});
    tbl.push_back('{6'b101011, 6'b111111, 1, 2, 1'b0, 1'b1});
    tbl.push_back('{6'b000100, 6'b000000, 0, 0, 1'b1, 1'b1});
    tbl.push_back('{6'b000100, 6'b000000, 0, 0, 1'b0, 1'b1});
    tbl.push_back('{6'b111111, 6'b100000, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{6'b000000, 6'b101010, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{6'b000010, 6'b000000, 0, 0, 1'b0, JMP});
    tbl.push_back('{6'b000000, 6'b100000, 0, 0, 1'b0, 1'b1});
    tbl.push_back('{6'b100011, 6'b000000, 1, 0, 1'b0, 1'b1});

    @(negedge clk);
    doReset();
    for (int v = 0; v < tbl.size(); v++)
      applyStimulus(tbl[v].op, tbl[v].fn, tbl[v].waitFetch, tbl[v].waitMem,
                    tbl[v].zero, 1'b0, tbl[v].legal, -1);

    // lw stalled in MEMRD, reset lands while the read is still pending.
    applyStimulus(6'b100011, 6'b000000, 0, 3, 1'b0, 1'b0, 1'b1, 5);

    // Seventeen adds push the 4-bit counter through all-ones back to zero and on to one.
    for (int k = 0; k < 17; k++)
      applyStimulus(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0, 1'b1, -1);

    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 5))
        0: rop = 6'b000000;
        1: rop = 6'b100011;
        2: rop = 6'b101011;
        3: rop = 6'b000100;
        4: rop = 6'b000010;
        default: rop = 6'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rfn = 6'b100000;
        1: rfn = 6'b100010;
        2: rfn = 6'b100100;
        3: rfn = 6'b100101;
        default: rfn = 6'($urandom);
      endcase
      applyStimulus(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1,
                    iclass(rop, rfn) != 0, -1);
    end

    // Final instruction boundary: retire count and sticky flag after the last instruction.
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checkOutput("final_retired", 32'(instr_retired), 32'(modelCnt));
    checkOutput("final_illegal", 32'(illegal), 32'(modelIllegal));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
